// File: rtl/aes_inv_key_expander_if.sv
// Key-load and round-key handshake bundle for aes_inv_key_expander.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready
// are both high; a producer holding valid keeps its payload stable until that edge.
interface aes_inv_key_expander_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  modport master (
    output key_in, key_valid, rk_ready,
    input  key_ready, rk_out, rk_round, rk_valid, busy, done
  );

  modport slave (
    input  key_in, key_valid, rk_ready,
    output key_ready, rk_out, rk_round, rk_valid, busy, done
  );
endinterface

// File: rtl/aes_inv_key_expander.sv
// Reverse-order AES-128 round-key generator: emits round keys 10..0 from the round-10 key.
// Define AES_INV_KEY_FWD_EN to accept the cipher key and run the forward schedule first.
module aes_inv_key_expander #(
  parameter int NR        = 10,
  parameter bit IDLE_ZERO = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_inv_key_expander_if.slave  bus,
  output logic [1:0]             dbg_state
);

`ifdef AES_INV_KEY_FWD_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EMIT = 2'd1, S_FWD = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EMIT = 2'd1} state_e;
`endif

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
  endfunction

  // Rcon for the key of round r (r = 1..10), already placed in the MS byte.
  function automatic logic [31:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return {c, 24'h0};
  endfunction

  // Round r key -> round r-1 key.
  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]   ^ k[63:32];
    p2 = k[63:32]  ^ k[95:64];
    p1 = k[95:64]  ^ k[127:96];
    p0 = k[127:96] ^ sub_rot_word(p3) ^ rcon(r);
    return {p0, p1, p2, p3};
  endfunction

`ifdef AES_INV_KEY_FWD_EN
  // Round r-1 key -> round r key.
  function automatic logic [127:0] fwd_step(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] w4, w5, w6, w7;
    w4 = k[127:96] ^ sub_rot_word(k[31:0]) ^ rcon(r);
    w5 = k[95:64] ^ w4;
    w6 = k[63:32] ^ w5;
    w7 = k[31:0]  ^ w6;
    return {w4, w5, w6, w7};
  endfunction
`endif

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.key_valid) begin
          key_d = bus.key_in;
`ifdef AES_INV_KEY_FWD_EN
          round_d = 4'd0;
          state_d = S_FWD;
`else
          round_d = 4'(NR);
          state_d = S_EMIT;
`endif
        end
      end
`ifdef AES_INV_KEY_FWD_EN
      S_FWD: begin
        key_d   = fwd_step(key_q, round_q + 4'd1);
        round_d = round_q + 4'd1;
        if (round_q == 4'(NR - 1)) state_d = S_EMIT;
      end
`endif
      S_EMIT: begin
        if (bus.rk_ready) begin
          if (round_q == 4'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (IDLE_ZERO) key_d = '0;
          end else begin
            key_d   = inv_step(key_q, round_q);
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign bus.key_ready = (state_q == S_IDLE);
  assign bus.rk_valid  = (state_q == S_EMIT);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rk_out    = key_q;
  assign bus.rk_round  = round_q;
  assign bus.done      = done_q;
  assign dbg_state     = state_q;

endmodule
